// File: rtl/bus_share_arbiter.sv
// rtl/bus_share_arbiter.sv - two-source round-robin arbiter feeding one registered output stage
// Define ARB_FIXED_PRIO_EN to make source 1 always win contention.
module bus_share_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic             req2,
  input  logic [WIDTH-1:0] data2,
  output logic             ack1,
  output logic             ack2,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             grant_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} stage_t;

  stage_t           state_q, state_d;
  logic [WIDTH-1:0] out_d;
  logic             grant_d;
  logic             ack1_d, ack2_d;
  logic             elig1, elig2;
  logic             stage_free, capture, pick2;

`ifndef ARB_FIXED_PRIO_EN
  // 0 = source 1 granted last, 1 = source 2 granted last
  logic last_grant;
`endif

  // A source whose ack is high this cycle still holds its already-captured word
  assign elig1 = req1 & ~ack1;
  assign elig2 = req2 & ~ack2;

  always_comb begin
    state_d    = state_q;
    out_d      = out;
    grant_d    = grant_id;
    ack1_d     = 1'b0;
    ack2_d     = 1'b0;
    stage_free = (state_q == EMPTY) | out_ready;
    capture    = stage_free & (elig1 | elig2);
`ifdef ARB_FIXED_PRIO_EN
    pick2      = elig2 & ~elig1;
`else
    pick2      = elig2 & (~elig1 | ~last_grant);
`endif

    case (state_q)
      EMPTY: if (capture) state_d = FULL;
      FULL:  if (out_ready && !capture) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (capture) begin
      out_d   = pick2 ? data2 : data1;
      grant_d = pick2;
      ack1_d  = ~pick2;
      ack2_d  = pick2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= EMPTY;
      out      <= '0;
      grant_id <= 1'b0;
      ack1     <= 1'b0;
      ack2     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out      <= out_d;
      grant_id <= grant_d;
      ack1     <= ack1_d;
      ack2     <= ack2_d;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  // Reset to source 2 so source 1 wins the first contention
  always_ff @(posedge clk) begin
    if (!reset)       last_grant <= 1'b1;
    else if (capture) last_grant <= pick2;
  end
`endif

  assign out_valid = (state_q == FULL);

endmodule
